pic_inta_sequencer: RTL and testbench

PIC_INTA_SEQUENCER -- requirements
Module: pic_inta_sequencer

---
 rtl/pic_inta_sequencer.sv | 134 +++++++++++++
 tb/tb_pic_inta_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259-style INTA handshake sequencer producing vector, cascade and ISR/IRR controls
module pic_inta_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inta_n,
   input  logic       int_req,
   input  logic [2:0] int_index,
   input  logic [4:0] icw2_base,
   input  logic       aeoi,
   input  logic       sngl,
   input  logic       sp_en,
   input  logic [7:0] icw3,
   input  logic [2:0] cas_in,
   output logic       int_o,
   output logic       freeze,
   output logic       isr_set,
   output logic       irr_clear,
   output logic [2:0] ack_index,
   output logic       vec_oe,
   output logic [7:0] vec_data,
   output logic [2:0] cas_out,
   output logic       cas_oe,
   output logic       aeoi_pulse,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;
   state_t     state_q, state_d;
   logic       inta_q, fall, rise;
   logic       int_q, int_d, freeze_q, freeze_d, isr_set_q, isr_set_d, irr_clear_q, irr_clear_d;
   logic       vec_oe_q, vec_oe_d, cas_oe_q, cas_oe_d, aeoi_pulse_q, aeoi_pulse_d;
   logic       busy_q, busy_d, spurious_q, spurious_d;
   logic [2:0] ack_index_q, ack_index_d, cas_out_q, cas_out_d;
   logic [7:0] vec_data_q, vec_data_d;

   assign fall = inta_q & ~inta_n;
   assign rise = ~inta_q & inta_n;

   // next-state and registered-output computation for the acknowledge sequence
   always_comb begin
      state_d      = state_q;
      int_d        = int_q;
      freeze_d     = freeze_q;
      isr_set_d    = 1'b0;
      irr_clear_d  = 1'b0;
      aeoi_pulse_d = 1'b0;
      ack_index_d  = ack_index_q;
      spurious_d   = spurious_q;
      vec_oe_d     = vec_oe_q;
      vec_data_d   = vec_data_q;
      cas_out_d    = cas_out_q;
      cas_oe_d     = cas_oe_q;
      case (state_q)
         IDLE: if (int_req) begin
            state_d = REQ;
            int_d   = 1'b1;
         end
         REQ: if (fall) begin
            state_d     = ACK1;
            int_d       = 1'b0;
            freeze_d    = 1'b1;
            ack_index_d = int_req ? int_index : 3'd7;
            spurious_d  = ~int_req;
            isr_set_d   = int_req;
            irr_clear_d = int_req;
            cas_oe_d    = ~sngl & sp_en & icw3[ack_index_d];
            cas_out_d   = cas_oe_d ? ack_index_d : 3'd0;
         end
         ACK1: if (rise) state_d = GAP;
         GAP: if (fall) begin
            state_d    = ACK2;
            vec_oe_d   = sngl | (sp_en ? ~icw3[ack_index_q] : (cas_in == icw3[2:0]));
            vec_data_d = vec_oe_d ? {icw2_base, ack_index_q} : 8'h00;
         end
         ACK2: if (rise) begin
            state_d      = IDLE;
            freeze_d     = 1'b0;
            vec_oe_d     = 1'b0;
            vec_data_d   = 8'h00;
            cas_oe_d     = 1'b0;
            cas_out_d    = 3'd0;
            aeoi_pulse_d = aeoi & ~spurious_q;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   // state, edge-detect and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         inta_q       <= 1'b1;
         int_q        <= 1'b0;
         freeze_q     <= 1'b0;
         isr_set_q    <= 1'b0;
         irr_clear_q  <= 1'b0;
         aeoi_pulse_q <= 1'b0;
         ack_index_q  <= 3'd0;
         spurious_q   <= 1'b0;
         vec_oe_q     <= 1'b0;
         vec_data_q   <= 8'h00;
         cas_out_q    <= 3'd0;
         cas_oe_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         inta_q       <= inta_n;
         int_q        <= int_d;
         freeze_q     <= freeze_d;
         isr_set_q    <= isr_set_d;
         irr_clear_q  <= irr_clear_d;
         aeoi_pulse_q <= aeoi_pulse_d;
         ack_index_q  <= ack_index_d;
         spurious_q   <= spurious_d;
         vec_oe_q     <= vec_oe_d;
         vec_data_q   <= vec_data_d;
         cas_out_q    <= cas_out_d;
         cas_oe_q     <= cas_oe_d;
         busy_q       <= busy_d;
      end
   end

   assign int_o      = int_q;
   assign freeze     = freeze_q;
   assign isr_set    = isr_set_q;
   assign irr_clear  = irr_clear_q;
   assign aeoi_pulse = aeoi_pulse_q;
   assign ack_index  = ack_index_q;
   assign vec_oe     = vec_oe_q;
   assign vec_data   = vec_data_q;
   assign cas_out    = cas_out_q;
   assign cas_oe     = cas_oe_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: cycle-table and hand-sequence checks of the INTA sequencer
module tb_pic_inta_sequencer;
   logic       clk = 1'b0;
   logic       rst_n, inta_n, int_req, aeoi, sngl, sp_en;
   logic [2:0] int_index, cas_in;
   logic [4:0] icw2_base;
   logic [7:0] icw3;
   logic       int_o, freeze, isr_set, irr_clear, vec_oe, cas_oe, aeoi_pulse, busy;
   logic [2:0] ack_index, cas_out;
   logic [7:0] vec_data;
   int         checks = 0;
   int         failures = 0;

   typedef struct packed {
      logic       intr, frz, isr, irr, aep, voe, coe, bsy;
      logic [2:0] ack, cas;
      logic [7:0] vec;
   } outs_t;

   typedef struct {
      string      name;
      logic       rst_n, inta_n, req;
      logic [2:0] idx;
      logic [13:0] cfg;
      outs_t      exp;
   } row_t;

   // cfg = {sngl, sp_en, aeoi, icw3, cas_in}
   localparam logic [13:0] S   = {1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
   localparam logic [13:0] SA  = {1'b1, 1'b1, 1'b1, 8'h00, 3'd0};
   localparam logic [13:0] M   = {1'b0, 1'b1, 1'b0, 8'h04, 3'd0};
   localparam logic [13:0] SL2 = {1'b0, 1'b0, 1'b0, 8'h02, 3'd2};
   localparam logic [13:0] SL1 = {1'b0, 1'b0, 1'b0, 8'h02, 3'd1};

   row_t rows[$];

   pic_inta_sequencer dut (
      .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .int_req(int_req), .int_index(int_index),
      .icw2_base(icw2_base), .aeoi(aeoi), .sngl(sngl), .sp_en(sp_en), .icw3(icw3), .cas_in(cas_in),
      .int_o(int_o), .freeze(freeze), .isr_set(isr_set), .irr_clear(irr_clear), .ack_index(ack_index),
      .vec_oe(vec_oe), .vec_data(vec_data), .cas_out(cas_out), .cas_oe(cas_oe),
      .aeoi_pulse(aeoi_pulse), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic outs_t o(input logic i, f, s, r, a, v, c, b, input logic [2:0] ak, cs, input logic [7:0] vd);
      o = '{intr:i, frz:f, isr:s, irr:r, aep:a, voe:v, coe:c, bsy:b, ack:ak, cas:cs, vec:vd};
   endfunction

   task automatic add(input string n, input logic rs, ia, rq, input logic [2:0] ix, input logic [13:0] cf, input outs_t e);
      row_t r;
      r.name = n; r.rst_n = rs; r.inta_n = ia; r.req = rq; r.idx = ix; r.cfg = cf; r.exp = e;
      rows.push_back(r);
   endtask

   task automatic drive(input logic rs, ia, rq, input logic [2:0] ix, input logic [13:0] cf);
      @(negedge clk);
      rst_n = rs; inta_n = ia; int_req = rq; int_index = ix;
      {sngl, sp_en, aeoi, icw3, cas_in} = cf;
      @(posedge clk);
      #1;
   endtask

   function automatic outs_t act();
      act = '{intr:int_o, frz:freeze, isr:isr_set, irr:irr_clear, aep:aeoi_pulse, voe:vec_oe,
              coe:cas_oe, bsy:busy, ack:ack_index, cas:cas_out, vec:vec_data};
   endfunction

   task automatic check(input string n, input outs_t e);
      outs_t a;
      a = act();
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got int=%b frz=%b isr=%b irr=%b aeoi=%b voe=%b coe=%b busy=%b ack=%0d cas=%0d vec=%h, want int=%b frz=%b isr=%b irr=%b aeoi=%b voe=%b coe=%b busy=%b ack=%0d cas=%0d vec=%h",
                  n, a.intr, a.frz, a.isr, a.irr, a.aep, a.voe, a.coe, a.bsy, a.ack, a.cas, a.vec,
                  e.intr, e.frz, e.isr, e.irr, e.aep, e.voe, e.coe, e.bsy, e.ack, e.cas, e.vec);
      end
   endtask

   initial begin
      int aeoi_cnt;
      icw2_base = 5'b01000;
      rst_n = 1'b0; inta_n = 1'b1; int_req = 1'b0; int_index = 3'd0;
      {sngl, sp_en, aeoi, icw3, cas_in} = S;
      //        name         rst ia rq idx cfg      int frz isr irr aep voe coe bsy ack cas vec
      add("reset",          0, 1, 0, 0, S,   o(0,0,0,0,0,0,0,0, 0,0,8'h00));
      add("single_req",     1, 1, 1, 3, S,   o(1,0,0,0,0,0,0,1, 0,0,8'h00));
      add("single_ack1",    1, 0, 1, 3, S,   o(0,1,1,1,0,0,0,1, 3,0,8'h00));
      add("single_ack1_hold",1,0, 1, 3, S,   o(0,1,0,0,0,0,0,1, 3,0,8'h00));
      add("single_gap",     1, 1, 1, 3, S,   o(0,1,0,0,0,0,0,1, 3,0,8'h00));
      add("single_gap_hold",1, 1, 1, 3, S,   o(0,1,0,0,0,0,0,1, 3,0,8'h00));
      add("single_ack2",    1, 0, 1, 3, S,   o(0,1,0,0,0,1,0,1, 3,0,8'h43));
      add("single_ack2_hold",1,0, 1, 3, S,   o(0,1,0,0,0,1,0,1, 3,0,8'h43));
      add("single_done",    1, 1, 0, 3, S,   o(0,0,0,0,0,0,0,0, 3,0,8'h00));
      add("spur_req",       1, 1, 1, 3, SA,  o(1,0,0,0,0,0,0,1, 3,0,8'h00));
      add("spur_req_drop",  1, 1, 0, 3, SA,  o(1,0,0,0,0,0,0,1, 3,0,8'h00));
      add("spur_ack1",      1, 0, 0, 3, SA,  o(0,1,0,0,0,0,0,1, 7,0,8'h00));
      add("spur_gap",       1, 1, 0, 3, SA,  o(0,1,0,0,0,0,0,1, 7,0,8'h00));
      add("spur_ack2",      1, 0, 0, 3, SA,  o(0,1,0,0,0,1,0,1, 7,0,8'h47));
      add("spur_done",      1, 1, 0, 3, SA,  o(0,0,0,0,0,0,0,0, 7,0,8'h00));
      add("spur_idle",      1, 1, 0, 3, SA,  o(0,0,0,0,0,0,0,0, 7,0,8'h00));
      add("idle_fall_ign",  1, 0, 0, 5, SA,  o(0,0,0,0,0,0,0,0, 7,0,8'h00));
      add("aeoi_req",       1, 1, 1, 5, SA,  o(1,0,0,0,0,0,0,1, 7,0,8'h00));
      add("aeoi_ack1",      1, 0, 1, 5, SA,  o(0,1,1,1,0,0,0,1, 5,0,8'h00));
      add("aeoi_gap",       1, 1, 1, 5, SA,  o(0,1,0,0,0,0,0,1, 5,0,8'h00));
      add("aeoi_ack2",      1, 0, 1, 5, SA,  o(0,1,0,0,0,1,0,1, 5,0,8'h45));
      add("aeoi_pulse",     1, 1, 0, 5, SA,  o(0,0,0,0,1,0,0,0, 5,0,8'h00));
      add("aeoi_pulse_end", 1, 1, 0, 5, SA,  o(0,0,0,0,0,0,0,0, 5,0,8'h00));
      add("mst2_req",       1, 1, 1, 2, M,   o(1,0,0,0,0,0,0,1, 5,0,8'h00));
      add("mst2_ack1",      1, 0, 1, 2, M,   o(0,1,1,1,0,0,1,1, 2,2,8'h00));
      add("mst2_gap",       1, 1, 1, 2, M,   o(0,1,0,0,0,0,1,1, 2,2,8'h00));
      add("mst2_ack2",      1, 0, 1, 2, M,   o(0,1,0,0,0,0,1,1, 2,2,8'h00));
      add("mst2_done",      1, 1, 0, 2, M,   o(0,0,0,0,0,0,0,0, 2,0,8'h00));
      add("mst5_req",       1, 1, 1, 5, M,   o(1,0,0,0,0,0,0,1, 2,0,8'h00));
      add("mst5_ack1",      1, 0, 1, 5, M,   o(0,1,1,1,0,0,0,1, 5,0,8'h00));
      add("mst5_gap",       1, 1, 1, 5, M,   o(0,1,0,0,0,0,0,1, 5,0,8'h00));
      add("mst5_ack2",      1, 0, 1, 5, M,   o(0,1,0,0,0,1,0,1, 5,0,8'h45));
      add("mst5_done",      1, 1, 0, 5, M,   o(0,0,0,0,0,0,0,0, 5,0,8'h00));
      add("slv_hit_req",    1, 1, 1, 1, SL2, o(1,0,0,0,0,0,0,1, 5,0,8'h00));
      add("slv_hit_ack1",   1, 0, 1, 1, SL2, o(0,1,1,1,0,0,0,1, 1,0,8'h00));
      add("slv_hit_gap",    1, 1, 1, 1, SL2, o(0,1,0,0,0,0,0,1, 1,0,8'h00));
      add("slv_hit_ack2",   1, 0, 1, 1, SL2, o(0,1,0,0,0,1,0,1, 1,0,8'h41));
      add("slv_hit_done",   1, 1, 0, 1, SL2, o(0,0,0,0,0,0,0,0, 1,0,8'h00));
      add("slv_miss_req",   1, 1, 1, 1, SL1, o(1,0,0,0,0,0,0,1, 1,0,8'h00));
      add("slv_miss_ack1",  1, 0, 1, 1, SL1, o(0,1,1,1,0,0,0,1, 1,0,8'h00));
      add("slv_miss_gap",   1, 1, 1, 1, SL1, o(0,1,0,0,0,0,0,1, 1,0,8'h00));
      add("slv_miss_ack2",  1, 0, 1, 1, SL1, o(0,1,0,0,0,0,0,1, 1,0,8'h00));
      add("slv_miss_done",  1, 1, 0, 1, SL1, o(0,0,0,0,0,0,0,0, 1,0,8'h00));
      add("rst_req",        1, 1, 1, 6, S,   o(1,0,0,0,0,0,0,1, 1,0,8'h00));
      add("rst_ack1",       1, 0, 1, 6, S,   o(0,1,1,1,0,0,0,1, 6,0,8'h00));
      add("rst_gap",        1, 1, 1, 6, S,   o(0,1,0,0,0,0,0,1, 6,0,8'h00));
      add("rst_in_gap",     0, 1, 1, 6, S,   o(0,0,0,0,0,0,0,0, 0,0,8'h00));
      add("post_rst_req",   1, 0, 1, 4, S,   o(1,0,0,0,0,0,0,1, 0,0,8'h00));
      add("post_rst_nofall",1, 0, 1, 4, S,   o(1,0,0,0,0,0,0,1, 0,0,8'h00));
      add("post_rst_rise",  1, 1, 1, 4, S,   o(1,0,0,0,0,0,0,1, 0,0,8'h00));
      add("post_rst_ack1",  1, 0, 1, 4, S,   o(0,1,1,1,0,0,0,1, 4,0,8'h00));
      add("post_rst_gap",   1, 1, 1, 4, S,   o(0,1,0,0,0,0,0,1, 4,0,8'h00));
      add("post_rst_ack2",  1, 0, 1, 4, S,   o(0,1,0,0,0,1,0,1, 4,0,8'h44));
      add("post_rst_done",  1, 1, 0, 4, S,   o(0,0,0,0,0,0,0,0, 4,0,8'h00));

      foreach (rows[k]) begin
         drive(rows[k].rst_n, rows[k].inta_n, rows[k].req, rows[k].idx, rows[k].cfg);
         check(rows[k].name, rows[k].exp);
      end

      // inta_n held low keeps ACK1, then ACK2; aeoi must pulse exactly once
      drive(1, 1, 1, 2, SA);
      check("hold_req", o(1,0,0,0,0,0,0,1, 4,0,8'h00));
      drive(1, 0, 1, 2, SA);
      check("hold_ack1", o(0,1,1,1,0,0,0,1, 2,0,8'h00));
      for (int c = 0; c < 10; c++) begin
         drive(1, 0, 0, 2, SA);
         check("hold_ack1_low", o(0,1,0,0,0,0,0,1, 2,0,8'h00));
      end
      drive(1, 1, 0, 2, SA);
      drive(1, 0, 0, 2, SA);
      for (int c = 0; c < 5; c++) begin
         drive(1, 0, 0, 2, SA);
         check("hold_ack2_low", o(0,1,0,0,0,1,0,1, 2,0,8'h42));
      end
      aeoi_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         drive(1, 1, 0, 2, SA);
         aeoi_cnt += int'(aeoi_pulse);
      end
      checks++;
      if (aeoi_cnt != 1) begin
         failures++;
         $display("FAIL aeoi_count: got %0d pulses, want 1", aeoi_cnt);
      end
      check("hold_final_idle", o(0,0,0,0,0,0,0,0, 2,0,8'h00));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
